mdu_iter_divider: RTL and testbench

Iterative radix-2 restoring divider for the multiply/divide unit in the execute stage. Accepts one 32-bit signed or unsigned DIV/DIVU operation at a time from the multi-cycle execute controller. Returns quotient and remainder a fixed number of cycles later, or after a short path on divide-by-zero. Result is held under a valid/ready handshake until the controller writes it into HI/LO.

---
 rtl/mdu_iter_divider.sv | 114 +++++++++++
 tb/tb_mdu_iter_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// signs re-applied in a final cycle, result held until the consumer takes it.
module mdu_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t                  r_state;
  logic [5:0]              r_cnt;
  logic [WIDTH-1:0]        r_part;
  logic [WIDTH-1:0]        r_qsh;
  logic [WIDTH-1:0]        r_dvsr;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic [WIDTH-1:0]        r_quot;
  logic [WIDTH-1:0]        r_rem;
  logic                    r_dbz;

  logic                    w_accept;
  logic [WIDTH:0]          w_shift;
  logic signed [WIDTH:0]   w_diff;
  logic                    w_qbit;

  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign w_accept    = in_valid & in_ready & ~flush;

  // The running remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the trial difference fits in WIDTH+1 signed bits.
  assign w_shift = {r_part, r_qsh[WIDTH-1]};
  assign w_diff  = $signed(w_shift) - $signed({1'b0, r_dvsr});
  assign w_qbit  = ~w_diff[WIDTH];

  // Datapath: operand magnitudes latched at accept, one restoring step per CALC cycle.
  // The dividend shift register fills with quotient bits as dividend bits leave.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_qsh   <= f_cond_neg(dividend, is_signed & dividend[WIDTH-1]);
      r_dvsr  <= f_cond_neg(divisor, is_signed & divisor[WIDTH-1]);
      r_part  <= '0;
      r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_r <= is_signed & dividend[WIDTH-1];
    end else if (r_state == S_CALC) begin
      r_part <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_qsh  <= {r_qsh[WIDTH-2:0], w_qbit};
    end
  end

  // Control and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= '0;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(WIDTH - 1)) r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_quot  <= f_cond_neg(r_qsh, r_neg_q);
          r_rem   <= f_cond_neg(r_part, r_neg_r);
          r_dbz   <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter_divider.sv
// Randomised and directed bench for mdu_iter_divider against an arithmetic
// reference of DIV/DIVU semantics, including latency and handshake behaviour.
module tb_mdu_iter_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, is_signed;
  logic         out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_q, last_r;

  mdu_iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // DIV/DIVU semantics: truncating division, remainder follows the dividend,
  // divide-by-zero returns all-ones and the raw dividend.
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(sgn, a, b, eq, er, ez);
    chk("in_ready_before_accept", in_ready, 1);
    is_signed = sgn; dividend = a; divisor = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, ez ? 0 : 33);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_quotient", quotient, eq);
        chk("hold_remainder", remainder, er);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
    last_q = eq; last_r = er;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 32'd100, 32'd7, 0);
    chk("divu_100_7_q", last_q, 32'd14);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_m7_2_r", last_r, 32'hFFFFFFFF);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("overflow_q", last_q, 32'h80000000);
    run_op(1'b1, 32'h80000005, 32'd0, 0);
    run_op(1'b0, 32'h80000005, 32'd0, 0);
    run_op(1'b0, 32'd1234567, 32'd89, 5);
    run_op(1'b1, 32'hFFFFFC18, 32'd0, 3);
    run_op(1'b1, 32'hFFFFFC18, 32'd13, 2);

    // Flush mid-calculation, then an immediate new operation.
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      chk("flush_pre_out_valid", out_valid, 0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_keeps_q", quotient, last_q);
    chk("flush_keeps_r", remainder, last_r);
    run_op(1'b0, 32'd81, 32'd9, 0);

    // Flush together with a request: nothing may be accepted.
    is_signed = 1'b0; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_block_in_ready", in_ready, 1);
    chk("flush_block_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("flush_block_later", out_valid, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int sel;
      a   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a calculation.
    run_op(1'b0, 32'd500, 32'd7, 0);
    is_signed = 1'b0; dividend = 32'h12345678; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    run_op(1'b1, 32'hFFFFFFAF, 32'd9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
